sc_statemachine_mult_seq: RTL
=============================

# sc_statemachine_mult_seq

Parametrised start/done sequencer for multi-cycle arithmetic units: drives up to NCH independent multiplier channels in round-robin order. Each channel gets a one-cycle start pulse, and the sequencer waits for that channel's done. A per-operation watchdog times out hung channels, and an optional idle gap separates operations. It sits between the robot control logic and a bank of sequential multipliers, and replaces the single-channel start/done loop.

## Interface
Parameters:
- NCH, 4: number of channels; valid range 2..16.
- CW, 16: width of the shared cycle counter used for timeout and gap.
- TIMEOUT, 1000: CHECK cycles allowed before the timeout fires; valid range 1..2^CW-1.
- GAP, 0: idle cycles inserted after each operation; valid range 0..2^CW-1.

Ports:
- SC_STATEMACHINE_MULT_SEQ_CLOCK_50  in  1  system clock; all state updates on rising edge.
- SC_STATEMACHINE_MULT_SEQ_RESET_InHigh  in  1  reset, asynchronous and active-high.
- SC_STATEMACHINE_MULT_SEQ_enable_InHigh  in  1  permits new operations; an operation in flight always completes.
- SC_STATEMACHINE_MULT_SEQ_chmask_In  in  NCH  channels participating in rotation.
- SC_STATEMACHINE_MULT_SEQ_done_InHigh  in  NCH  per-channel done; level or pulse.
- SC_STATEMACHINE_MULT_SEQ_start_Out  out  NCH  one-hot start pulse, one cycle.
- SC_STATEMACHINE_MULT_SEQ_chsel_Out  out  clog2(NCH)  index of the current or most recent channel.
- SC_STATEMACHINE_MULT_SEQ_busy_Out  out  1  high in START, CHECK and GAP.
- SC_STATEMACHINE_MULT_SEQ_timeout_Out  out  1  one-cycle pulse when the watchdog fires.
- SC_STATEMACHINE_MULT_SEQ_errcount_Out  out  8  saturating count of timeouts.

## Operation
- States:
  - IDLE: no operation.
  - START: asserts start_Out[chsel] only.
  - CHECK: waits for done[chsel].
  - GAP: counts idle cycles.
- All outputs are Moore, decoded from registered state, chsel, and registered timeout and errcount.
- IDLE -> START when enable=1 and chmask≠0. On that transition chsel loads the next channel; otherwise the state stays IDLE.
- Next channel is the first set bit of chmask strictly above chsel, wrapping to bit 0. If the only set bit is chsel, chsel is selected again.
- START -> CHECK unconditionally; the counter clears to 0.
- done[chsel] is ignored in START. done on other channels is ignored in every state.
- CHECK exits on done[chsel]=1 or counter = TIMEOUT-1:
  - If GAP>0, go to GAP with the counter cleared.
  - Otherwise, if enable=1 and chmask≠0, go to START with chsel advanced.
  - Otherwise go to IDLE.
- While in CHECK without done, the counter increments.
- Timeout: fires at counter = TIMEOUT-1 with done[chsel]=0. timeout_Out pulses the next cycle, and errcount increments, saturating at 255.
- done and timeout in the same cycle: done wins; no timeout pulse, no errcount change.
- GAP counts GAP cycles, then applies the same START/IDLE decision as the CHECK exit.
- chmask and enable are sampled only at channel selection. Changing chmask mid-operation does not abort the current channel.
- Reset mid-operation (any state) has immediate effect:
  - state = IDLE, start_Out = 0, busy = 0, timeout = 0, errcount = 0.
  - chsel = NCH-1, so the first pick after reset is the lowest set mask bit.

## Timing
- Enable sampled high in IDLE at edge k: start_Out is high during cycle k..k+1, and busy goes high at edge k.
- Start pulse width is always exactly one cycle.
- GAP=0, done returned in the first CHECK cycle: start pulses repeat every 2 cycles.
- General operation period: 2 + (CHECK cycles - 1) + GAP.
- Timeout path: START, then TIMEOUT CHECK cycles, then timeout_Out is high for one cycle, coincident with the first GAP, START or IDLE cycle.
- Latency from done to the next start: 1 cycle when GAP=0, GAP+1 cycles otherwise.

## Structure
- Shared package sc_mult_seq_pkg:
  - state encoding localparams (IDLE=0, START=1, CHECK=2, GAP=3), 2-bit.
  - ERRW=8.
  - function clog2.
- Sub-module sc_roundrobin_pick: combinational. Inputs are the mask and the current index; outputs are the next index and a valid flag. It is reused by other arbiters in the design.
- Top holds the state register, chsel register, counter, and errcount, with a single next-state always block plus an output decode.

## Test plan
- Reset, NCH=4, mask=4'b1111, enable=1, done returned 1 cycle after each start -> start_Out sequence 0001,0010,0100,1000,0001, with starts spaced 2 cycles apart.
- mask=4'b0101, GAP=3 -> channel order 0,2,0. The next start comes 4 cycles after each done, and busy stays high throughout.
- TIMEOUT=8, done withheld on channel 1 -> timeout_Out pulses exactly once after 8 CHECK cycles, errcount=1, and the next start goes to channel 2.
- done[chsel] and counter=TIMEOUT-1 in the same cycle -> no timeout pulse, errcount unchanged.
- 300 consecutive timeouts -> errcount saturates at 255.
- Mask changed to 0 mid-CHECK, then done -> returns to IDLE, busy=0. Separately, reset asserted mid-CHECK -> all outputs take reset values immediately, and the first start after release goes to the lowest set mask bit.

Source files
------------

// File: rtl/sc_mult_seq_pkg.sv
// Shared types and helpers for the multi-channel start/done sequencer and its arbiters.
package sc_mult_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_CHECK = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  localparam int unsigned ERRW = 8;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/sc_roundrobin_pick.sv
// Combinational round-robin picker: first set mask bit strictly above cur_i, wrapping to bit 0.
module sc_roundrobin_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  mask_i,
  input  logic [IW-1:0] cur_i,
  output logic [IW-1:0] nxt_o,
  output logic          valid_o
);

  logic [IW-1:0] above_idx;
  logic [IW-1:0] wrap_idx;
  logic          above_vld;

  // wrap_idx ends up as the lowest set bit, so a lone bit equal to cur_i re-selects itself.
  always_comb begin
    above_idx = '0;
    wrap_idx  = '0;
    above_vld = 1'b0;
    valid_o   = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (mask_i[i]) begin
        if (!valid_o) begin
          wrap_idx = IW'(i);
          valid_o  = 1'b1;
        end
        if (!above_vld && (i > 32'(cur_i))) begin
          above_idx = IW'(i);
          above_vld = 1'b1;
        end
      end
    end
    nxt_o = above_vld ? above_idx : wrap_idx;
  end

endmodule

// File: rtl/sc_statemachine_mult_seq.sv
// Round-robin start/done sequencer for a bank of sequential multipliers,
// with per-operation watchdog, saturating timeout count and optional idle gap.
module sc_statemachine_mult_seq
  import sc_mult_seq_pkg::*;
#(
  parameter int unsigned NCH     = 4,
  parameter int unsigned CW      = 16,
  parameter int unsigned TIMEOUT = 1000,
  parameter int unsigned GAP     = 0
) (
  input  logic                   SC_STATEMACHINE_MULT_SEQ_CLOCK_50,
  input  logic                   SC_STATEMACHINE_MULT_SEQ_RESET_InHigh,
  input  logic                   SC_STATEMACHINE_MULT_SEQ_enable_InHigh,
  input  logic [NCH-1:0]         SC_STATEMACHINE_MULT_SEQ_chmask_In,
  input  logic [NCH-1:0]         SC_STATEMACHINE_MULT_SEQ_done_InHigh,
  output logic [NCH-1:0]         SC_STATEMACHINE_MULT_SEQ_start_Out,
  output logic [clog2(NCH)-1:0]  SC_STATEMACHINE_MULT_SEQ_chsel_Out,
  output logic                   SC_STATEMACHINE_MULT_SEQ_busy_Out,
  output logic                   SC_STATEMACHINE_MULT_SEQ_timeout_Out,
  output logic [ERRW-1:0]        SC_STATEMACHINE_MULT_SEQ_errcount_Out
);

  localparam int unsigned   CHW      = clog2(NCH);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP - 1);

  state_e          state_q, state_d;
  logic [CHW-1:0]  chsel_q, chsel_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [ERRW-1:0] err_q, err_d;
  logic            tmo_q, tmo_d;
  logic [CHW-1:0]  pick_idx;
  logic            pick_vld;
  logic            done_cur;
  logic            go_next;

  sc_roundrobin_pick #(
    .N  (NCH),
    .IW (CHW)
  ) u_pick (
    .mask_i  (SC_STATEMACHINE_MULT_SEQ_chmask_In),
    .cur_i   (chsel_q),
    .nxt_o   (pick_idx),
    .valid_o (pick_vld)
  );

  assign done_cur = SC_STATEMACHINE_MULT_SEQ_done_InHigh[chsel_q];

  always_comb begin
    state_d = state_q;
    chsel_d = chsel_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    tmo_d   = 1'b0;
    go_next = 1'b0;
    case (state_q)
      ST_IDLE:  go_next = 1'b1;
      ST_START: begin
        state_d = ST_CHECK;
        cnt_d   = '0;
      end
      ST_CHECK: begin
        if (done_cur || (cnt_q == TO_LAST)) begin
          // done on the last watchdog cycle takes priority over the timeout
          if (!done_cur) begin
            tmo_d = 1'b1;
            if (err_q != '1) err_d = err_q + 1'b1;
          end
          if (GAP > 0) begin
            state_d = ST_GAP;
            cnt_d   = '0;
          end else begin
            go_next = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) go_next = 1'b1;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    // IDLE, CHECK exit and GAP end share one selection step: enable/mask are only sampled here.
    if (go_next) begin
      if (SC_STATEMACHINE_MULT_SEQ_enable_InHigh && pick_vld) begin
        state_d = ST_START;
        chsel_d = pick_idx;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge SC_STATEMACHINE_MULT_SEQ_CLOCK_50 or posedge SC_STATEMACHINE_MULT_SEQ_RESET_InHigh) begin
    if (SC_STATEMACHINE_MULT_SEQ_RESET_InHigh) begin
      state_q <= ST_IDLE;
      chsel_q <= CHW'(NCH - 1);
      cnt_q   <= '0;
      err_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      chsel_q <= chsel_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    SC_STATEMACHINE_MULT_SEQ_start_Out = '0;
    if (state_q == ST_START) SC_STATEMACHINE_MULT_SEQ_start_Out = NCH'(1) << chsel_q;
    SC_STATEMACHINE_MULT_SEQ_chsel_Out    = chsel_q;
    SC_STATEMACHINE_MULT_SEQ_busy_Out     = (state_q != ST_IDLE);
    SC_STATEMACHINE_MULT_SEQ_timeout_Out  = tmo_q;
    SC_STATEMACHINE_MULT_SEQ_errcount_Out = err_q;
  end

endmodule
